// File: rtl/hex_disp_ctrl.sv
// Six-digit seven-segment display controller: loads six nibbles and writes them digit by digit.
// Optional blinking overlay is enabled by defining HEXDISP_BLINK_EN.

module enc7led (
    input  logic [3:0] vinp,
    input  logic       enchx,
    output logic [6:0] seg
);

    // Active-low segment patterns ordered {g,f,e,d,c,b,a}
    always_comb begin
        seg = 7'b1001001;
        case (vinp)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1011000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = enchx ? 7'b0001000 : 7'b1001001;
            4'hB: seg = enchx ? 7'b0000011 : 7'b1001001;
            4'hC: seg = enchx ? 7'b1000110 : 7'b1001001;
            4'hD: seg = enchx ? 7'b0100001 : 7'b1001001;
            4'hE: seg = enchx ? 7'b0000110 : 7'b1001001;
            4'hF: seg = enchx ? 7'b0001110 : 7'b1001001;
            default: seg = 7'b1001001;
        endcase
    end

endmodule

module hex_disp_ctrl #(
    parameter int STEP_DIV = 1
`ifdef HEXDISP_BLINK_EN
    ,
    parameter int BLINK_DIV = 25000000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [23:0] ld_data,
    input  logic        ld_hex,
    input  logic        ld_lzb,
`ifdef HEXDISP_BLINK_EN
    input  logic        blink_en,
`endif
    output logic        done,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5
);

    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [6:0] BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [CW-1:0]   step_q, step_d;
    logic [23:0]     data_q, data_d;
    logic            hexMode_q, hexMode_d;
    logic            lzb_q, lzb_d;
    logic            zeroAbove_q, zeroAbove_d;
    logic [6:0]      hold_q [6];
    logic [6:0]      hold_d [6];

    logic [3:0]      nibble;
    logic [6:0]      encSeg;
    logic [6:0]      digitSeg;

    assign nibble = data_q[{idx_q, 2'b00} +: 4];

    enc7led u_enc (
        .vinp  (nibble),
        .enchx (hexMode_q),
        .seg   (encSeg)
    );

    // A digit is blanked only while every digit above it has also been zero
    assign digitSeg = (lzb_q && (idx_q != 3'd0) && (nibble == 4'h0) && zeroAbove_q)
                      ? BLANK : encSeg;

    assign ld_ready = (state_q == IDLE);
    assign done     = (state_q == DONE);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        step_d      = step_q;
        data_d      = data_q;
        hexMode_d   = hexMode_q;
        lzb_d       = lzb_q;
        zeroAbove_d = zeroAbove_q;
        for (int i = 0; i < 6; i++) begin
            hold_d[i] = hold_q[i];
        end
        case (state_q)
            IDLE: begin
                if (ld_valid) begin
                    data_d      = ld_data;
                    hexMode_d   = ld_hex;
                    lzb_d       = ld_lzb;
                    idx_d       = 3'd5;
                    step_d      = '0;
                    zeroAbove_d = 1'b1;
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                if (step_q == CW'(STEP_DIV - 1)) begin
                    step_d         = '0;
                    hold_d[idx_q]  = digitSeg;
                    zeroAbove_d    = zeroAbove_q && (nibble == 4'h0);
                    if (idx_q == 3'd0) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q - 3'd1;
                    end
                end else begin
                    step_d = step_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            step_q      <= '0;
            data_q      <= 24'd0;
            hexMode_q   <= 1'b0;
            lzb_q       <= 1'b0;
            zeroAbove_q <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                hold_q[i] <= BLANK;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            step_q      <= step_d;
            data_q      <= data_d;
            hexMode_q   <= hexMode_d;
            lzb_q       <= lzb_d;
            zeroAbove_q <= zeroAbove_d;
            for (int i = 0; i < 6; i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end

`ifdef HEXDISP_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] blinkCnt_q;
    logic          phaseOn_q;
    logic          blankAll;

    // Free-running blink timebase, independent of the scan FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            blinkCnt_q <= '0;
            phaseOn_q  <= 1'b1;
        end else if (blinkCnt_q == BW'(BLINK_DIV - 1)) begin
            blinkCnt_q <= '0;
            phaseOn_q  <= ~phaseOn_q;
        end else begin
            blinkCnt_q <= blinkCnt_q + BW'(1);
        end
    end

    assign blankAll = blink_en && !phaseOn_q;

    assign hex0 = blankAll ? BLANK : hold_q[0];
    assign hex1 = blankAll ? BLANK : hold_q[1];
    assign hex2 = blankAll ? BLANK : hold_q[2];
    assign hex3 = blankAll ? BLANK : hold_q[3];
    assign hex4 = blankAll ? BLANK : hold_q[4];
    assign hex5 = blankAll ? BLANK : hold_q[5];
`else
    assign hex0 = hold_q[0];
    assign hex1 = hold_q[1];
    assign hex2 = hold_q[2];
    assign hex3 = hold_q[3];
    assign hex4 = hold_q[4];
    assign hex5 = hold_q[5];
`endif

endmodule

// File: tb/tb_hex_disp_ctrl.sv
// Directed self-checking bench for hex_disp_ctrl: one instance with STEP_DIV=1, one with STEP_DIV=3.
// Blink checks are compiled in only when HEXDISP_BLINK_EN is defined.

module tb_hex_disp_ctrl;

    localparam logic [6:0] BL = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst1, rst3;
    logic        valid1, valid3;
    logic        ready1, ready3;
    logic [23:0] data1, data3;
    logic        hx1, hx3;
    logic        lzb1, lzb3;
    logic        done1, done3;
    logic [6:0]  h1 [6];
    logic [6:0]  h3 [6];
`ifdef HEXDISP_BLINK_EN
    logic        blink1;
    logic        blink3;
    int          sinceRst;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

`ifdef HEXDISP_BLINK_EN
    hex_disp_ctrl #(.STEP_DIV(1), .BLINK_DIV(4)) dut1 (
        .clk(clk), .rst(rst1), .ld_valid(valid1), .ld_ready(ready1), .ld_data(data1),
        .ld_hex(hx1), .ld_lzb(lzb1), .blink_en(blink1), .done(done1),
        .hex0(h1[0]), .hex1(h1[1]), .hex2(h1[2]), .hex3(h1[3]), .hex4(h1[4]), .hex5(h1[5])
    );
    hex_disp_ctrl #(.STEP_DIV(3), .BLINK_DIV(4)) dut3 (
        .clk(clk), .rst(rst3), .ld_valid(valid3), .ld_ready(ready3), .ld_data(data3),
        .ld_hex(hx3), .ld_lzb(lzb3), .blink_en(blink3), .done(done3),
        .hex0(h3[0]), .hex1(h3[1]), .hex2(h3[2]), .hex3(h3[3]), .hex4(h3[4]), .hex5(h3[5])
    );

    // Edges seen since the last reset edge of dut1, used to predict the blink phase
    always @(posedge clk) begin
        if (rst1) sinceRst <= 0;
        else      sinceRst <= sinceRst + 1;
    end
`else
    hex_disp_ctrl #(.STEP_DIV(1)) dut1 (
        .clk(clk), .rst(rst1), .ld_valid(valid1), .ld_ready(ready1), .ld_data(data1),
        .ld_hex(hx1), .ld_lzb(lzb1), .done(done1),
        .hex0(h1[0]), .hex1(h1[1]), .hex2(h1[2]), .hex3(h1[3]), .hex4(h1[4]), .hex5(h1[5])
    );
    hex_disp_ctrl #(.STEP_DIV(3)) dut3 (
        .clk(clk), .rst(rst3), .ld_valid(valid3), .ld_ready(ready3), .ld_data(data3),
        .ld_hex(hx3), .ld_lzb(lzb3), .done(done3),
        .hex0(h3[0]), .hex1(h3[1]), .hex2(h3[2]), .hex3(h3[3]), .hex4(h3[4]), .hex5(h3[5])
    );
`endif

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [41:0] packHex(input int sel);
        if (sel == 3) return {h3[5], h3[4], h3[3], h3[2], h3[1], h3[0]};
        return {h1[5], h1[4], h1[3], h1[2], h1[1], h1[0]};
    endfunction

    function automatic logic doneOf(input int sel);
        return (sel == 3) ? done3 : done1;
    endfunction

    function automatic logic readyOf(input int sel);
        return (sel == 3) ? ready3 : ready1;
    endfunction

    // Present one load for exactly one acceptance edge; returns #1 after that edge
    task automatic applyStimulus(input int sel, input logic [23:0] d, input logic h, input logic z);
        checkOutput("ready before load", 64'(readyOf(sel)), 64'd1);
        if (sel == 3) begin
            valid3 = 1'b1; data3 = d; hx3 = h; lzb3 = z;
        end else begin
            valid1 = 1'b1; data1 = d; hx1 = h; lzb1 = z;
        end
        @(posedge clk); #1;
        valid1 = 1'b0;
        valid3 = 1'b0;
        checkOutput("busy after accept", 64'(readyOf(sel)), 64'd0);
    endtask

    task automatic waitDone(input int sel, input int startCnt, input int expCnt, input string tag);
        int n = startCnt;
        while (!doneOf(sel) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput({tag, " done latency"}, 64'(n), 64'(expCnt));
        @(posedge clk); #1;
        checkOutput({tag, " done one cycle"}, 64'(doneOf(sel)), 64'd0);
        checkOutput({tag, " ready returns"}, 64'(readyOf(sel)), 64'd1);
    endtask

    task automatic runLoad1(input logic [23:0] d, input logic h, input logic z,
                            input logic [41:0] exp, input string tag);
        applyStimulus(1, d, h, z);
        waitDone(1, 0, 6, tag);
        checkOutput({tag, " digits"}, 64'(packHex(1)), 64'(exp));
    endtask

    initial begin
        rst1 = 1'b1; rst3 = 1'b1;
        valid1 = 1'b1; valid3 = 1'b1;
        data1 = 24'h777777; data3 = 24'h777777;
        hx1 = 1'b0; hx3 = 1'b0; lzb1 = 1'b0; lzb3 = 1'b0;
`ifdef HEXDISP_BLINK_EN
        blink1 = 1'b0; blink3 = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst1 = 1'b0; rst3 = 1'b0;
        valid1 = 1'b0; valid3 = 1'b0;
        checkOutput("reset digits", 64'(packHex(1)), 64'({6{BL}}));
        checkOutput("reset done", 64'(done1), 64'd0);
        checkOutput("reset ready", 64'(ready1), 64'd1);
        @(posedge clk); #1;
        checkOutput("load during reset dropped", 64'(ready1), 64'd1);

        runLoad1(24'h000042, 1'b0, 1'b1,
                 {BL, BL, BL, BL, 7'b0011001, 7'b0100100}, "lzb 42");
        runLoad1(24'hABCDEF, 1'b1, 1'b0,
                 {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110}, "hex ABCDEF");
        runLoad1(24'h00000A, 1'b0, 1'b1,
                 {BL, BL, BL, BL, BL, 7'b1001001}, "dec A");
        runLoad1(24'h000000, 1'b0, 1'b1,
                 {BL, BL, BL, BL, BL, 7'b1000000}, "all zero");
        runLoad1(24'h102030, 1'b0, 1'b1,
                 {7'b1111001, 7'b1000000, 7'b0100100, 7'b1000000, 7'b0110000, 7'b1000000}, "inner zeros");
        runLoad1(24'h001203, 1'b1, 1'b1,
                 {BL, BL, 7'b1111001, 7'b0100100, 7'b1000000, 7'b0110000}, "lzb 1203");
        runLoad1(24'h895600, 1'b1, 1'b0,
                 {7'b0000000, 7'b0010000, 7'b0010010, 7'b0000010, 7'b1000000, 7'b1000000}, "digits 8956");
        runLoad1(24'h000007, 1'b0, 1'b0,
                 {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1011000}, "no lzb 7");

        // Slow scan with a load attempt while busy
        applyStimulus(3, 24'h123456, 1'b0, 1'b0);
        @(posedge clk); #1;
        valid3 = 1'b1; data3 = 24'h111111; hx3 = 1'b1; lzb3 = 1'b1;
        @(posedge clk); #1;
        checkOutput("busy load ignored", 64'(ready3), 64'd0);
        valid3 = 1'b0;
        waitDone(3, 2, 18, "slow 123456");
        checkOutput("slow 123456 digits", 64'(packHex(3)),
                    64'({7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010}));

        // Reset arrives while idx=3, after digits 5 and 4 have been rewritten
        applyStimulus(3, 24'h987654, 1'b0, 1'b0);
        repeat (6) begin
            @(posedge clk); #1;
        end
        checkOutput("partial hex5", 64'(h3[5]), 64'(7'b0010000));
        checkOutput("partial hex4", 64'(h3[4]), 64'(7'b0000000));
        checkOutput("partial hex3 held", 64'(h3[3]), 64'(7'b0110000));
        rst3 = 1'b1;
        @(posedge clk); #1;
        rst3 = 1'b0;
        checkOutput("midscan reset digits", 64'(packHex(3)), 64'({6{BL}}));
        checkOutput("midscan reset ready", 64'(ready3), 64'd1);
        checkOutput("midscan reset done", 64'(done3), 64'd0);

`ifdef HEXDISP_BLINK_EN
        runLoad1(24'h123456, 1'b0, 1'b0,
                 {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010}, "blink load");
        blink1 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            checkOutput("blink hex0", 64'(h1[0]),
                        64'((((sinceRst / 4) % 2) == 0) ? 7'b0000010 : BL));
        end
        blink1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checkOutput("steady hex5", 64'(h1[5]), 64'(7'b1111001));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hex_disp_ctrl.md
HEX_DISP_CTRL -- requirements
Module: hex_disp_ctrl

Interface
REQ-001 Parameter: STEP_DIV, 1, clock cycles spent per digit during a scan (integer >= 1).
REQ-002 Parameter: BLINK_DIV, 25000000, cycles per blink half-period (present only with HEXDISP_BLINK_EN).
REQ-003 clk  input  1  single system clock, all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ld_valid  input  1  load request.
REQ-006 ld_ready  output  1  controller idle, load accepted when ld_valid&&ld_ready.
REQ-007 ld_data  input  24  six nibbles, digit0=[3:0] ... digit5=[23:20].
REQ-008 ld_hex  input  1  hex mode: nibbles 10..15 shown as A..F.
REQ-009 ld_lzb  input  1  leading-zero blanking enable.
REQ-010 done  output  1  one-cycle pulse when all six digits have been written.
REQ-011 hex0..hex5  output  7 each  active-low segments {g,f,e,d,c,b,a}, registered.

Function
REQ-012 States: IDLE, SCAN, DONE; ld_ready = (state==IDLE), combinational.
REQ-013 IDLE: on ld_valid&&ld_ready, capture ld_data, ld_hex, ld_lzb; set idx=5, step counter=0; go SCAN.
REQ-014 ld_valid while ld_ready=0 is ignored, nothing captured, no queueing.
REQ-015 SCAN: one shared instance of enc7led (vinp=captured nibble[idx], enchx=captured hex flag) encodes the current digit.
REQ-016 SCAN: step counter counts 0..STEP_DIV-1; at count STEP_DIV-1 write hex[idx] at the clock edge, reset counter, decrement idx.
REQ-017 Encoding: 0..9 standard digits (0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1011000, 8=0000000, 9=0010000).
REQ-018 Encoding, hex mode: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-019 Encoding, non-hex mode: nibbles 10..15 write 1001001.
REQ-020 Blanking: with lzb=1, write 1111111 instead if idx!=0, nibble==0, and every higher digit was zero; digit0 is never blanked.
REQ-021 After idx=0 is written, go DONE; DONE asserts done for exactly one cycle, then IDLE.
REQ-022 Latency: acceptance edge + 6*STEP_DIV cycles to the last write; done is high in the following cycle; ld_ready returns the cycle after that.
REQ-023 Undriven digits hold their previous value during a scan (digit-wise update, tearing accepted).
REQ-024 idx and step counter are sized $clog2 of their range; no wrap beyond 0..5.

Reset
REQ-025 rst=1 at any edge, including mid-scan: state=IDLE, hex0..hex5=1111111, done=0, idx=0, step counter=0, captured registers=0.
REQ-026 ld_ready reads 1 in the cycle after reset; a load coincident with rst is discarded.

Configuration
REQ-027 Macro HEXDISP_BLINK_EN defined: adds input blink_en (1 bit) and a free-running BLINK_DIV counter toggling a phase bit (reset phase=on, counter=0).
REQ-028 With blink_en=1 and phase=off, hex0..hex5 are forced to 1111111; the hold registers and FSM are unaffected.
REQ-029 Macro undefined: no blink_en port, no blink counter; hex outputs are the hold registers directly.

Verification
REQ-030 Reset: assert rst 2 cycles -> hex0..5=1111111, done=0, ld_ready=1 next cycle.
REQ-031 STEP_DIV=1, load 24'h000042, hex=0, lzb=1 -> hex5..hex2=1111111, hex1=0011001, hex0=0100100; done on cycle 7 after acceptance; ld_ready on cycle 8.
REQ-032 Load 24'hABCDEF, hex=1, lzb=0 -> hex5..hex0 = 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
REQ-033 Load 24'h00000A, hex=0, lzb=1 -> hex0=1001001, others blank; then 24'h000000, lzb=1 -> hex0=1000000, others blank.
REQ-034 STEP_DIV=3: mid-scan ld_valid with 24'h111111 is ignored, and the original value completes after 18 cycles. Then rst asserted at idx=3 -> all blank next cycle, state IDLE.
REQ-035 With HEXDISP_BLINK_EN, BLINK_DIV=4, blink_en=1 after loading 24'h123456 -> outputs alternate value/1111111 every 4 cycles; blink_en=0 -> steady value.
